// File: rtl/encoder_param_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : encoder_param_stream_sink
// Purpose  : Valid/ready sink for parameter-vector beats. Captures one full
//            tensor into an internal RAM, then exposes it through a
//            ROM-compatible read port (addr/ce/q, 2 enabled-cycle latency).
// Options  : PARAM_SINK_CHECKSUM_EN adds a running-XOR checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_param_stream_sink #(
    parameter int PARAM_TENSOR_SIZE_DIM_0 = 32,
    parameter int PARAM_TENSOR_SIZE_DIM_1 = 1,
    parameter int PARAM_PRECISION_0       = 16,
    parameter int PARAM_PARALLELISM_DIM_0 = 1,
    parameter int PARAM_PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH   = (PARAM_TENSOR_SIZE_DIM_0 * PARAM_TENSOR_SIZE_DIM_1) /
                               (PARAM_PARALLELISM_DIM_0 * PARAM_PARALLELISM_DIM_1),
    parameter int WORD_WIDTH = PARAM_PRECISION_0 * PARAM_PARALLELISM_DIM_0 * PARAM_PARALLELISM_DIM_1,
    parameter int AWIDTH     = $clog2(IN_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARAM_PRECISION_0-1:0] data_in [PARAM_PARALLELISM_DIM_0*PARAM_PARALLELISM_DIM_1],
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    input  logic                         clear,
    output logic                         loaded,
    output logic [AWIDTH-1:0]            beat_count,
    input  logic [AWIDTH-1:0]            rd_addr,
    input  logic                         rd_ce,
    output logic [WORD_WIDTH-1:0]        rd_data
`ifdef PARAM_SINK_CHECKSUM_EN
    ,
    output logic [WORD_WIDTH-1:0]        checksum
`endif
);

    localparam int ELEMS = PARAM_PARALLELISM_DIM_0 * PARAM_PARALLELISM_DIM_1;
    // The extra counter bit only exists to represent IN_DEPTH itself; the RAM
    // needs one bit fewer (rounded up to a power of two).
    localparam int RAM_AW    = (AWIDTH > 1) ? (AWIDTH - 1) : 1;
    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam logic [AWIDTH-1:0] LAST_BEAT = AWIDTH'(IN_DEPTH - 1);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [AWIDTH-1:0]       beat_count_q, beat_count_d;
    logic [WORD_WIDTH-1:0]   stage0_q;
    logic [WORD_WIDTH-1:0]   rd_data_q;
    logic [WORD_WIDTH-1:0]   ram [RAM_DEPTH];
    logic [WORD_WIDTH-1:0]   wr_word;
    logic                    wr_en;
    logic                    unused_rd_addr_msb;

    // Pack the beat elements: element j lands in bits [P*j +: P].
    for (genvar j = 0; j < ELEMS; j++) begin : g_pack
        assign wr_word[PARAM_PRECISION_0*j +: PARAM_PRECISION_0] = data_in[j];
    end

    // A beat is written only while loading; clear wins over a same-cycle beat.
    assign wr_en = data_in_valid & (state_q == LOAD) & ~clear;

    // Addresses at or above IN_DEPTH simply alias into the RAM (undefined data).
    assign unused_rd_addr_msb = rd_addr[AWIDTH-1];

    // State and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
        end
    end

    // Next-state, counter advance and state-decoded handshake outputs.
    always_comb begin
        state_d       = state_q;
        beat_count_d  = beat_count_q;
        data_in_ready = 1'b0;
        loaded        = 1'b0;
        case (state_q)
            LOAD: begin
                data_in_ready = 1'b1;
                if (wr_en) begin
                    beat_count_d = beat_count_q + AWIDTH'(1);
                    if (beat_count_q == LAST_BEAT) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                loaded = 1'b1;
            end
        endcase
        if (clear) begin
            state_d      = LOAD;
            beat_count_d = '0;
        end
    end

    // Parameter RAM write port; contents deliberately survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[beat_count_q[RAM_AW-1:0]] <= wr_word;
        end
    end

    // Two-stage ROM-style read pipeline; reads see pre-write data on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage0_q  <= '0;
            rd_data_q <= '0;
        end else if (rd_ce) begin
            stage0_q  <= ram[rd_addr[RAM_AW-1:0]];
            rd_data_q <= stage0_q;
        end
    end

    assign beat_count = beat_count_q;
    assign rd_data    = rd_data_q;

`ifdef PARAM_SINK_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum_q;

    // Running XOR of every word written since reset or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (clear) begin
            checksum_q <= '0;
        end else if (wr_en) begin
            checksum_q <= checksum_q ^ wr_word;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder_param_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_param_stream_sink
// Purpose  : Randomized scoreboard bench for encoder_param_stream_sink.
//            A tensor-level model predicts accepted beats and RAM contents;
//            monitors compare DUT handshakes and read data against queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_param_stream_sink;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in [1];
    logic        data_in_valid;
    logic        data_in_ready;
    logic        clear;
    logic        loaded;
    logic [5:0]  beat_count;
    logic [5:0]  rd_addr;
    logic        rd_ce;
    logic [15:0] rd_data;
    logic        rd_tag;

    // Wide instance: four 16-bit elements per beat, eight beats per tensor.
    logic [15:0] d4 [4];
    logic        v4, clr4, ready4, loaded4, ce4;
    logic [3:0]  cnt4, addr4;
    logic [63:0] rd4;
`ifdef PARAM_SINK_CHECKSUM_EN
    logic [15:0] checksum;
    logic [63:0] checksum4;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: tensor image, fill level and full flag.
    logic [15:0] ref_mem [DEPTH];
    int          ref_count;
    bit          ref_full;
    int          accq [$];
    logic [15:0] rdq  [$];

    encoder_param_stream_sink u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .clear(clear), .loaded(loaded),
        .beat_count(beat_count), .rd_addr(rd_addr), .rd_ce(rd_ce), .rd_data(rd_data)
`ifdef PARAM_SINK_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    encoder_param_stream_sink #(.PARAM_PARALLELISM_DIM_0(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(d4), .data_in_valid(v4),
        .data_in_ready(ready4), .clear(clr4), .loaded(loaded4),
        .beat_count(cnt4), .rd_addr(addr4), .rd_ce(ce4), .rd_data(rd4)
`ifdef PARAM_SINK_CHECKSUM_EN
        , .checksum(checksum4)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One bus cycle: check status left by the previous edge, then drive new inputs
    // and advance the model.
    task automatic step(input bit vld, input logic [15:0] v, input bit clr,
                        input bit ce, input bit tag, input int raddr);
        @(negedge clk);
        check("ready", {63'd0, data_in_ready}, {63'd0, !ref_full});
        check("loaded", {63'd0, loaded}, {63'd0, ref_full});
        check("beat_count", {58'd0, beat_count}, 64'(ref_count));
        data_in_valid = vld;
        data_in[0]    = v;
        clear         = clr;
        rd_ce         = ce;
        rd_tag        = tag;
        rd_addr       = 6'(raddr);
        if (tag) rdq.push_back(ref_mem[raddr]);
        if (clr) begin
            ref_count = 0;
            ref_full  = 1'b0;
        end else if (vld && !ref_full) begin
            accq.push_back(ref_count);
            ref_mem[ref_count] = v;
            ref_count++;
            ref_full = (ref_count == DEPTH);
        end
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic beat(input logic [15:0] v);
        step(1'b1, v, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Tagged reads with random rd_ce gaps, then flush the pipeline.
    task automatic rd_burst(input int addrs[$]);
        foreach (addrs[i]) begin
            while ($urandom_range(2) == 0) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0);
            step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, addrs[i]);
        end
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 0);
        idle();
    endtask

    // Accept monitor: every DUT handshake must match a model-predicted address.
    always @(posedge clk) begin
        if (!rst && data_in_valid && data_in_ready && !clear) begin
            if (accq.size() == 0) begin
                check("acc_unexpected", 64'd1, 64'd0);
            end else begin
                check("acc_addr", {58'd0, beat_count}, 64'(accq.pop_front()));
            end
        end
    end

    // Read monitor: shadow the 2-stage pipeline to know when rd_data is a tagged read.
    bit rv0, rv1, rfresh;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rv0 <= 1'b0; rv1 <= 1'b0; rfresh <= 1'b0;
        end else begin
            rfresh <= rd_ce;
            if (rd_ce) begin
                rv1 <= rv0;
                rv0 <= rd_tag;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rfresh && rv1) begin
            if (rdq.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
            else check("rd_data", {48'd0, rd_data}, {48'd0, rdq.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          addrs[$];
        logic [63:0] words4 [8];
        logic [63:0] xor4;

        rst = 1'b1; data_in[0] = '0; data_in_valid = 0; clear = 0;
        rd_addr = '0; rd_ce = 0; rd_tag = 0;
        for (int j = 0; j < 4; j++) d4[j] = '0;
        v4 = 0; clr4 = 0; ce4 = 0; addr4 = '0;
        ref_count = 0; ref_full = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rd_data", {48'd0, rd_data}, 64'd0);

        // Full stream with valid held high, then beats offered while FULL.
        for (int i = 0; i < DEPTH; i++) beat(16'(i));
        for (int i = 0; i < 3; i++) beat(16'h0021 + 16'(i));
        idle();
        addrs = '{5, 0, 31, 17};
        rd_burst(addrs);

        // Reload the same values with random valid gaps.
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(1) == 0) idle();
            beat(16'(i));
        end
        idle();
        addrs.delete();
        for (int i = 0; i < DEPTH; i++) addrs.push_back(i);
        rd_burst(addrs);

        // clear colliding with a beat at beat_count=10 drops that beat.
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) beat(16'h2000 + 16'(i));
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 0);
        // First reload beat collides with a read of addr 0: old data expected.
        step(1'b1, 16'h1000, 1'b0, 1'b1, 1'b1, 0);
        for (int i = 1; i < DEPTH; i++) beat(16'h1000 + 16'(i));
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 0);
        idle();
        addrs = '{0, 10, 31};
        rd_burst(addrs);

        // Asynchronous reset between clock edges after 7 beats.
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 7; i++) beat(16'h3000 + 16'(i));
        @(posedge clk);
        #2;
        data_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_ready", {63'd0, data_in_ready}, 64'd1);
        check("arst_loaded", {63'd0, loaded}, 64'd0);
        check("arst_count", {58'd0, beat_count}, 64'd0);
        check("arst_rd_data", {48'd0, rd_data}, 64'd0);
        ref_count = 0; ref_full = 0;
        @(negedge clk);
        rst = 1'b0;
        beat(16'hAAAA);
        idle();
        addrs = '{0, 1};
        rd_burst(addrs);

        // Wide instance: first beat {4,3,2,1}, the rest random.
        xor4 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                d4[j] = (k == 0) ? 16'(j + 1) : 16'($urandom);
                words4[k][16*j +: 16] = d4[j];
            end
            xor4 = xor4 ^ words4[k];
            v4 = 1'b1;
        end
        @(negedge clk);
        v4 = 1'b0;
        check("w_loaded", {63'd0, loaded4}, 64'd1);
        check("w_ready", {63'd0, ready4}, 64'd0);
        check("w_count", {60'd0, cnt4}, 64'd8);
`ifdef PARAM_SINK_CHECKSUM_EN
        check("w_checksum", checksum4, xor4);
`endif
        for (int a = 0; a < 8; a += 7) begin
            addr4 = 4'(a); ce4 = 1'b1;
            repeat (2) @(negedge clk);
            ce4 = 1'b0;
            if (a == 0) begin
                check("w_lo", {48'd0, rd4[15:0]}, 64'd1);
                check("w_hi", {48'd0, rd4[63:48]}, 64'd4);
            end else begin
                check("w_word7", rd4, words4[7]);
            end
        end

        repeat (2) @(negedge clk);
        check("acc_drain", 64'(accq.size()), 64'd0);
        check("rd_drain", 64'(rdq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
